// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Latency: none (types, constants and one helper function only).
// Backpressure: not applicable.
package mem_ctrl_pkg;

  localparam int DAT_W = 32;

  // Controller phases; IDLE is where arbitration happens.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFETCH = 2'd1,
    ST_LOAD   = 2'd2,
    ST_STORE  = 2'd3
  } state_e;

  // Access length codes on ls_len_i; code 3 behaves as a word.
  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  // Address bits [17:16] value that selects the I/O region.
  localparam logic [1:0] IO_HI_DEF = 2'b11;

  // Which requester was served most recently.
  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_LS = 1'b1
  } gnt_e;

  // One load/store request as captured from the load-store buffer.
  typedef struct packed {
    logic             wr;
    logic [1:0]       len;
    logic [DAT_W-1:0] addr;
    logic [DAT_W-1:0] data;
  } ls_req_t;

  // Number of bytes moved for a length code.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      LEN_WORD: return 3'd4;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request, response and byte-RAM signals of the memory controller.
// Latency: wires only.
// Backpressure: requesters wait for their completion pulse; io_buffer_full stalls I/O stores.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic             ic_en_i;
  logic [DAT_W-1:0] ic_pc_i;
  logic             ic_en_o;
  logic [DAT_W-1:0] ic_ins_o;

  logic             ls_en_i;
  logic             ls_wr_i;
  logic [1:0]       ls_len_i;
  logic [DAT_W-1:0] ls_addr_i;
  logic [DAT_W-1:0] ls_data_i;
  logic             ls_en_o;
  logic [DAT_W-1:0] ls_data_o;

  logic [7:0]       mem_din;
  logic [7:0]       mem_dout;
  logic [DAT_W-1:0] mem_a;
  logic             mem_wr;
  logic             io_buffer_full;

  // Controller side.
  modport slave (
    input  ic_en_i, ic_pc_i, ls_en_i, ls_wr_i, ls_len_i, ls_addr_i, ls_data_i,
           mem_din, io_buffer_full,
    output ic_en_o, ic_ins_o, ls_en_o, ls_data_o, mem_dout, mem_a, mem_wr
  );

  // Requesters plus RAM side.
  modport master (
    output ic_en_i, ic_pc_i, ls_en_i, ls_wr_i, ls_len_i, ls_addr_i, ls_data_i,
           mem_din, io_buffer_full,
    input  ic_en_o, ic_ins_o, ls_en_o, ls_data_o, mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates I-cache fetches and load/stores onto a byte-wide RAM port.
// Latency: word fetch done 5 edges after grant, N-byte load N+1, N-byte store N.
// Backpressure: requests held pending until served; I/O stores stall on io_buffer_full; en low freezes all.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_HI = IO_HI_DEF
) (
  input logic        clk,
  input logic        rst_n,
  input logic        en,
  input logic        br_flag,
  mem_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic             ic_pend_q, ic_pend_d;
  logic [DAT_W-1:0] ic_pc_q, ic_pc_d;
  logic             ls_pend_q, ls_pend_d;
  ls_req_t          ls_req_q, ls_req_d;
  gnt_e             last_q, last_d;
  logic [2:0]       cnt_q, cnt_d;       // edges since grant (reads) / bytes written (stores)
  logic [2:0]       nbytes_q, nbytes_d;
  logic [DAT_W-1:0] base_q, base_d;
  logic [DAT_W-1:0] wdata_q, wdata_d;
  logic             io_q, io_d;
  logic [DAT_W-1:0] rdata_q, rdata_d;
  logic [DAT_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]       mem_dout_q, mem_dout_d;
  logic             mem_wr_q, mem_wr_d;
  logic             ic_en_o_q, ic_en_o_d;
  logic [DAT_W-1:0] ic_ins_q, ic_ins_d;
  logic             ls_en_o_q, ls_en_o_d;
  logic [DAT_W-1:0] ls_data_q, ls_data_d;

  // A flush at the sampling edge kills both a pending fetch and a fresh fetch pulse.
  logic             ic_req, ls_req, gnt_ic, gnt_ls, io_cur;
  logic [DAT_W-1:0] ic_addr;
  ls_req_t          ls_in, ls_cur;
  logic [2:0]       ridx;
  logic [DAT_W-1:0] rd_merge;
  logic [7:0]       wbyte;

  assign ic_req  = !br_flag && (ic_pend_q || bus.ic_en_i);
  assign ic_addr = ic_pend_q ? ic_pc_q : bus.ic_pc_i;
  assign ls_req  = ls_pend_q || bus.ls_en_i;
  assign ls_in   = {bus.ls_wr_i, bus.ls_len_i, bus.ls_addr_i, bus.ls_data_i};
  assign ls_cur  = ls_pend_q ? ls_req_q : ls_in;
  assign io_cur  = (ls_cur.addr[17:16] == IO_HI);

  // Byte arriving now belongs to position cnt-2; rdata is cleared at grant so OR-in is safe.
  assign ridx     = cnt_q - 3'd2;
  assign rd_merge = rdata_q | ({24'd0, bus.mem_din} << {ridx[1:0], 3'b000});
  assign wbyte    = 8'(wdata_q >> {cnt_q[1:0], 3'b000});

  // Next-state, request capture, arbitration and RAM-port sequencing.
  always_comb begin
    state_d    = state_q;
    ic_pend_d  = ic_pend_q;
    ic_pc_d    = ic_pc_q;
    ls_pend_d  = ls_pend_q;
    ls_req_d   = ls_req_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    nbytes_d   = nbytes_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    io_d       = io_q;
    rdata_d    = rdata_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;
    ic_en_o_d  = 1'b0;
    ic_ins_d   = ic_ins_q;
    ls_en_o_d  = 1'b0;
    ls_data_d  = ls_data_q;
    gnt_ic     = 1'b0;
    gnt_ls     = 1'b0;

    if (br_flag) begin
      ic_pend_d = 1'b0;
    end else if (bus.ic_en_i && !ic_pend_q) begin
      ic_pend_d = 1'b1;
      ic_pc_d   = bus.ic_pc_i;
    end
    if (bus.ls_en_i && !ls_pend_q) begin
      ls_pend_d = 1'b1;
      ls_req_d  = ls_in;
    end

    case (state_q)
      ST_IDLE: begin
        gnt_ls = ls_req && (!ic_req || last_q == GNT_IC);
        gnt_ic = ic_req && !gnt_ls;
        if (gnt_ic) begin
          ic_pend_d = 1'b0;
          last_d    = GNT_IC;
          base_d    = ic_addr;
          nbytes_d  = 3'd4;
          rdata_d   = '0;
          mem_a_d   = ic_addr;
          cnt_d     = 3'd1;
          state_d   = ST_IFETCH;
        end else if (gnt_ls) begin
          ls_pend_d = 1'b0;
          last_d    = GNT_LS;
          base_d    = ls_cur.addr;
          nbytes_d  = len_bytes(ls_cur.len);
          wdata_d   = ls_cur.data;
          io_d      = io_cur;
          rdata_d   = '0;
          mem_a_d   = ls_cur.addr;
          if (ls_cur.wr) begin
            state_d = ST_STORE;
            if (io_cur && bus.io_buffer_full) begin
              cnt_d = 3'd0;
            end else begin
              mem_wr_d   = 1'b1;
              mem_dout_d = ls_cur.data[7:0];
              cnt_d      = 3'd1;
            end
          end else begin
            state_d = ST_LOAD;
            cnt_d   = 3'd1;
          end
        end
      end

      ST_IFETCH, ST_LOAD: begin
        if (state_q == ST_IFETCH && br_flag) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q < nbytes_q) mem_a_d = base_q + {29'd0, cnt_q};
          if (cnt_q >= 3'd2) rdata_d = rd_merge;
          if (cnt_q == nbytes_q + 3'd1) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            if (state_q == ST_IFETCH) begin
              ic_en_o_d = 1'b1;
              ic_ins_d  = rd_merge;
            end else begin
              ls_en_o_d = 1'b1;
              ls_data_d = rd_merge;
            end
          end
        end
      end

      ST_STORE: begin
        if (cnt_q < nbytes_q) begin
          // A full I/O buffer holds the byte counter; the write is retried later.
          if (!(io_q && bus.io_buffer_full)) begin
            mem_wr_d   = 1'b1;
            mem_a_d    = base_q + {29'd0, cnt_q};
            mem_dout_d = wbyte;
            cnt_d      = cnt_q + 3'd1;
          end
        end else begin
          ls_en_o_d = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = 3'd0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State register; en low holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ic_pend_q  <= 1'b0;
      ic_pc_q    <= '0;
      ls_pend_q  <= 1'b0;
      ls_req_q   <= '0;
      last_q     <= GNT_IC;
      cnt_q      <= '0;
      nbytes_q   <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      io_q       <= 1'b0;
      rdata_q    <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      ic_en_o_q  <= 1'b0;
      ic_ins_q   <= '0;
      ls_en_o_q  <= 1'b0;
      ls_data_q  <= '0;
    end else if (en) begin
      state_q    <= state_d;
      ic_pend_q  <= ic_pend_d;
      ic_pc_q    <= ic_pc_d;
      ls_pend_q  <= ls_pend_d;
      ls_req_q   <= ls_req_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      nbytes_q   <= nbytes_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      io_q       <= io_d;
      rdata_q    <= rdata_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      ic_en_o_q  <= ic_en_o_d;
      ic_ins_q   <= ic_ins_d;
      ls_en_o_q  <= ls_en_o_d;
      ls_data_q  <= ls_data_d;
    end
  end

  // Write strobe is masked while frozen so a held byte is never written twice.
  assign bus.mem_wr    = mem_wr_q & en;
  assign bus.mem_a     = mem_a_q;
  assign bus.mem_dout  = mem_dout_q;
  assign bus.ic_en_o   = ic_en_o_q;
  assign bus.ic_ins_o  = ic_ins_q;
  assign bus.ls_en_o   = ls_en_o_q;
  assign bus.ls_data_o = ls_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table of single requests plus corner-case sequences.
// Latency counted in rising edges after the request-sampling edge.
// A byte-RAM model answers reads one cycle after the address and applies writes.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n, en, br_flag;

  mem_ctrl_if bus ();

  mem_ctrl #(.IO_HI(2'b11)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .br_flag (br_flag),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [logic [31:0]];
  int n_chk = 0;
  int n_fail = 0;
  int both_cnt = 0;

  // RAM model: registered read data, write on mem_wr.
  always @(posedge clk) begin
    bus.mem_din <= ram.exists(bus.mem_a) ? ram[bus.mem_a] : 8'h00;
    if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
  end

  // The two completion pulses must never coincide.
  always @(negedge clk) begin
    if (bus.ic_en_o && bus.ls_en_o) both_cnt++;
  end

  function automatic logic [7:0] rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_ic;
    logic        wr;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_wrc;
  } vec_t;

  // Issue one request on an idle controller and wait for its completion pulse.
  task automatic run_req(input vec_t v, output int lat, output logic [31:0] dat, output int wrc);
    @(negedge clk);
    if (v.is_ic) begin
      bus.ic_en_i = 1'b1;
      bus.ic_pc_i = v.addr;
    end else begin
      bus.ls_en_i   = 1'b1;
      bus.ls_wr_i   = v.wr;
      bus.ls_len_i  = v.len;
      bus.ls_addr_i = v.addr;
      bus.ls_data_i = v.wdata;
    end
    lat = 999;
    dat = '0;
    wrc = 0;
    for (int e = 0; e <= 20; e++) begin
      @(negedge clk);
      if (e == 0) begin
        bus.ic_en_i = 1'b0;
        bus.ls_en_i = 1'b0;
      end
      if (bus.mem_wr) wrc++;
      if (v.is_ic ? bus.ic_en_o : bus.ls_en_o) begin
        lat = e;
        dat = v.is_ic ? bus.ic_ins_o : bus.ls_data_o;
        break;
      end
    end
  endtask

  vec_t vecs[14];

  initial begin
    int lat, wrc, ls_at, ic_at, ic_cnt, first_wr, cnt;
    logic [31:0] dat, ls_val, ic_val;

    vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'h0050_0013, 5, 0};
    vecs[1]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0200, 32'h0,         32'h4433_2211, 5, 0};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0203, 32'h0,         32'h0000_0044, 2, 0};
    vecs[3]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0201, 32'h0,         32'h0000_3322, 3, 0};
    vecs[4]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0400, 32'h0,         32'h3CC3_5AA5, 5, 0};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0300, 32'h1234_BEEF, 32'h0,         2, 2};
    vecs[6]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0300, 32'h0,         32'h0000_BEEF, 5, 0};
    vecs[7]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0302, 32'hAABB_CC77, 32'h0,         1, 1};
    vecs[8]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0300, 32'h0,         32'h0077_BEEF, 5, 0};
    vecs[9]  = '{1'b0, 1'b1, 2'd2, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 32'h0,         4, 4};
    vecs[10] = '{1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         32'hDEAD_BEEF, 5, 0};
    vecs[11] = '{1'b1, 1'b0, 2'd2, 32'h0000_0000, 32'h0,         32'h0000_DEAD, 5, 0};
    vecs[12] = '{1'b0, 1'b1, 2'd2, 32'h0003_0010, 32'h0102_0304, 32'h0,         4, 4};
    vecs[13] = '{1'b0, 1'b0, 2'd1, 32'h0003_0012, 32'h0,         32'h0000_0102, 3, 0};

    ram[32'h100] = 8'h13; ram[32'h101] = 8'h00; ram[32'h102] = 8'h50; ram[32'h103] = 8'h00;
    ram[32'h200] = 8'h11; ram[32'h201] = 8'h22; ram[32'h202] = 8'h33; ram[32'h203] = 8'h44;
    ram[32'h400] = 8'hA5; ram[32'h401] = 8'h5A; ram[32'h402] = 8'hC3; ram[32'h403] = 8'h3C;

    bus.ic_en_i = 1'b0; bus.ic_pc_i = '0;
    bus.ls_en_i = 1'b0; bus.ls_wr_i = 1'b0; bus.ls_len_i = '0;
    bus.ls_addr_i = '0; bus.ls_data_i = '0;
    bus.io_buffer_full = 1'b0;
    en = 1'b1; br_flag = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset ic_en_o",   bus.ic_en_o,   0);
    check("reset ic_ins_o",  bus.ic_ins_o,  0);
    check("reset ls_en_o",   bus.ls_en_o,   0);
    check("reset ls_data_o", bus.ls_data_o, 0);
    check("reset mem_a",     bus.mem_a,     0);
    check("reset mem_dout",  bus.mem_dout,  0);
    check("reset mem_wr",    bus.mem_wr,    0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests right after reset: load goes first, fetch follows.
    @(negedge clk);
    bus.ic_en_i = 1'b1; bus.ic_pc_i = 32'h100;
    bus.ls_en_i = 1'b1; bus.ls_wr_i = 1'b0; bus.ls_len_i = 2'd2; bus.ls_addr_i = 32'h200;
    ls_at = -1; ic_at = -1; ls_val = '0; ic_val = '0;
    for (int e = 0; e <= 20; e++) begin
      @(negedge clk);
      if (e == 0) begin bus.ic_en_i = 1'b0; bus.ls_en_i = 1'b0; end
      if (bus.ls_en_o && ls_at < 0) begin ls_at = e; ls_val = bus.ls_data_o; end
      if (bus.ic_en_o && ic_at < 0) begin ic_at = e; ic_val = bus.ic_ins_o; end
    end
    check("arb ls_en_o edge", ls_at, 5);
    check("arb load data", ls_val, 32'h4433_2211);
    check("arb ic_en_o edge", ic_at, 11);
    check("arb fetch data", ic_val, 32'h0050_0013);

    for (int i = 0; i < 14; i++) begin
      run_req(vecs[i], lat, dat, wrc);
      check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d write cycles", i), wrc, vecs[i].exp_wrc);
      if (!vecs[i].wr) check($sformatf("vec%0d data", i), dat, vecs[i].exp_data);
    end
    check("wrap byte 0xFFFFFFFF", rd(32'hFFFF_FFFF), 32'hBE);
    check("io store byte 0x30013", rd(32'h0003_0013), 32'h01);

    // I/O store stalled by a full buffer for three edges.
    @(negedge clk);
    bus.ls_en_i = 1'b1; bus.ls_wr_i = 1'b1; bus.ls_len_i = 2'd0;
    bus.ls_addr_i = 32'h0003_0000; bus.ls_data_i = 32'h0000_005C;
    bus.io_buffer_full = 1'b1;
    lat = 999; wrc = 0; first_wr = -1;
    for (int e = 0; e <= 20; e++) begin
      @(negedge clk);
      if (e == 0) bus.ls_en_i = 1'b0;
      if (bus.mem_wr) begin wrc++; if (first_wr < 0) first_wr = e; end
      if (e == 2) bus.io_buffer_full = 1'b0;
      if (bus.ls_en_o) begin lat = e; break; end
    end
    check("io stall first write edge", first_wr, 3);
    check("io stall write cycles", wrc, 1);
    check("io stall latency", lat, 4);
    check("io stall byte", rd(32'h0003_0000), 32'h5C);

    // Flush during a fetch after two bytes; queued load still completes.
    @(negedge clk);
    bus.ic_en_i = 1'b1; bus.ic_pc_i = 32'h100;
    ls_at = -1; ls_val = '0; ic_cnt = 0;
    for (int e = 0; e <= 25; e++) begin
      @(negedge clk);
      if (bus.ic_en_o) ic_cnt++;
      if (bus.ls_en_o && ls_at < 0) begin ls_at = e; ls_val = bus.ls_data_o; end
      if (e == 0) begin
        bus.ic_en_i = 1'b0;
        bus.ls_en_i = 1'b1; bus.ls_wr_i = 1'b0; bus.ls_len_i = 2'd2; bus.ls_addr_i = 32'h400;
      end
      if (e == 1) bus.ls_en_i = 1'b0;
      if (e == 3) begin br_flag = 1'b1; bus.ic_en_i = 1'b1; bus.ic_pc_i = 32'h200; end
      if (e == 4) begin br_flag = 1'b0; bus.ic_en_i = 1'b0; end
    end
    check("flush ic_en_o count", ic_cnt, 0);
    check("flush load edge", ls_at, 10);
    check("flush load data", ls_val, 32'h3CC3_5AA5);

    // en low for two edges mid-store: no duplicate write, store resumes.
    @(negedge clk);
    bus.ls_en_i = 1'b1; bus.ls_wr_i = 1'b1; bus.ls_len_i = 2'd1;
    bus.ls_addr_i = 32'h600; bus.ls_data_i = 32'h0000_9988;
    lat = 999; wrc = 0;
    for (int e = 0; e <= 20; e++) begin
      @(negedge clk);
      if (e == 0) bus.ls_en_i = 1'b0;
      if (bus.mem_wr) wrc++;
      if (bus.ls_en_o) begin lat = e; break; end
      if (e == 0) begin
        en = 1'b0;
        #1 check("en low masks mem_wr", bus.mem_wr, 0);
      end
      if (e == 2) en = 1'b1;
    end
    check("en freeze latency", lat, 4);
    check("en freeze write cycles", wrc, 2);
    check("en freeze byte 0x600", rd(32'h600), 32'h88);
    check("en freeze byte 0x601", rd(32'h601), 32'h99);

    // Reset while the second byte of a word store is on the bus.
    @(negedge clk);
    bus.ls_en_i = 1'b1; bus.ls_wr_i = 1'b1; bus.ls_len_i = 2'd2;
    bus.ls_addr_i = 32'h500; bus.ls_data_i = 32'h1122_3344;
    wrc = 0;
    for (int e = 0; e <= 1; e++) begin
      @(negedge clk);
      if (e == 0) bus.ls_en_i = 1'b0;
      if (bus.mem_wr) wrc++;
    end
    check("pre-reset write cycles", wrc, 2);
    rst_n = 1'b0;
    #1;
    check("mid reset mem_wr",   bus.mem_wr,   0);
    check("mid reset mem_a",    bus.mem_a,    0);
    check("mid reset mem_dout", bus.mem_dout, 0);
    check("mid reset ls_en_o",  bus.ls_en_o,  0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      if (bus.ls_en_o || bus.mem_wr) cnt++;
    end
    check("post reset activity", cnt, 0);
    check("aborted store byte 0x500", rd(32'h500), 32'h44);
    check("aborted store byte 0x501", rd(32'h501), 32'h00);

    check("pulse exclusivity", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter IO_HI, default 2'b11, meaning: ls_addr_i[17:16] value that marks the I/O region.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 en  in  1  global ready; low freezes all state.
REQ-005 br_flag  in  1  misprediction flush, cancels instruction traffic only.
REQ-006 ic_en_i  in  1  one-cycle fetch request pulse from instruction cache.
REQ-007 ic_pc_i  in  32  fetch address, valid with ic_en_i.
REQ-008 ic_en_o  out  1  one-cycle pulse, ic_ins_o valid.
REQ-009 ic_ins_o  out  32  fetched word, little-endian.
REQ-010 ls_en_i  in  1  one-cycle load/store request pulse from load-store buffer.
REQ-011 ls_wr_i  in  1  1 = store, 0 = load.
REQ-012 ls_len_i  in  2  0 byte, 1 half, 2 word; 3 illegal, treated as word.
REQ-013 ls_addr_i  in  32  byte address.
REQ-014 ls_data_i  in  32  store data, low bytes used.
REQ-015 ls_en_o  out  1  one-cycle completion pulse for load or store.
REQ-016 ls_data_o  out  32  load data, zero-extended.
REQ-017 mem_din  in  8  RAM read byte, valid one cycle after its address.
REQ-018 mem_dout  out  8  RAM write byte.
REQ-019 mem_a  out  32  RAM byte address.
REQ-020 mem_wr  out  1  1 = write mem_dout to mem_a this cycle.
REQ-021 io_buffer_full  in  1  I/O write buffer full.

Function
REQ-022 Requests are latched into per-requester pending registers on the edge their pulse is sampled; a new pulse while pending overwrites nothing (requesters never issue a second pulse before completion).
REQ-023 States: IDLE, IFETCH, LOAD, STORE; IDLE grants at the same edge a request is sampled or pending.
REQ-024 Arbitration in IDLE: single request is granted; both present, the requester not granted last wins; the last-grant bit resets to IC.
REQ-025 Read (IFETCH/LOAD) of N bytes: grant edge E0 drives mem_a=base; edge Ek drives mem_a=base+k for k<N; byte s captured from mem_din at E(s+2).
REQ-026 Word fetch on idle controller: ic_en_o high in the cycle after E5, i.e. 5 edges after the sampling edge; load of N bytes completes N+1 edges after grant.
REQ-027 Store of N bytes: edges E0..E(N-1) drive mem_wr=1, mem_a=base+k, mem_dout=ls_data_i byte k; at EN mem_wr=0, ls_en_o=1.
REQ-028 Store with ls_addr_i[17:16]==IO_HI while io_buffer_full=1: mem_wr=0, byte counter holds, resumes when io_buffer_full=0.
REQ-029 On completion edge state returns to IDLE; next grant at the following edge at earliest; mem_wr=0 and mem_a holds in IDLE.
REQ-030 ic_en_o and ls_en_o are pulses of exactly one cycle, never both high in the same cycle.
REQ-031 br_flag high at an edge: IC pending cleared, IFETCH aborted to IDLE, no ic_en_o; an ic_en_i sampled at that same edge is dropped.
REQ-032 br_flag never affects pending or in-flight LOAD/STORE.
REQ-033 en low: all registers hold; mem_wr driven 0 combinationally so no byte is written twice.
REQ-034 Address arithmetic is 32-bit modulo 2^32; base+k wraps without error.

Reset
REQ-035 rst_n low, asynchronously: state IDLE, pendings and counters 0, last-grant IC, all outputs 0.
REQ-036 Reset mid-transaction abandons it; no completion pulse follows reset release.

Structure
REQ-037 DAT_W, state encodings, length codes and IO_HI default live in the shared header src/head.v.
REQ-038 Single module, no sub-module.

Verification
REQ-039 Fetch pc=0x100 holding bytes 13,00,50,00 -> ic_ins_o=0x00500013, ic_en_o 5 edges after request.
REQ-040 Same-cycle ic_en_i and ls_en_i load word 0x200 after reset -> LSB served first, IC fetch starts the edge after ls_en_o.
REQ-041 Store half 0xBEEF to 0x300 -> mem_wr 2 cycles, bytes EF at 0x300, BE at 0x301, ls_en_o 2 edges after grant.
REQ-042 Store byte to 0x30000 with io_buffer_full high 3 cycles -> no mem_wr for 3 cycles, then one write, ls_en_o.
REQ-043 br_flag during IFETCH after 2 bytes -> IDLE, no ic_en_o; concurrent pending load completes unaffected.
REQ-044 rst_n low during STORE byte 1 of word -> outputs 0 immediately, no ls_en_o after release.
